// File: rtl/strip_width_updater_pkg.sv
// Shared constants, FSM state type and ID range helper for the strip-width path.
package strip_width_updater_pkg;

    localparam int unsigned ID_W           = 4;
    localparam int unsigned DEF_NUM_STRIPS = 16;
    localparam int unsigned DEF_MAX_WIDTH  = 128;
    localparam int unsigned DEF_WIDTH_W    = 8;
    localparam int unsigned NUM_RD_PORTS   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // True when a strip ID addresses an existing table entry.
    function automatic logic id_in_range(input logic [ID_W-1:0] id,
                                         input int unsigned num_strips);
        return 32'(id) < num_strips;
    endfunction

endpackage

// File: rtl/strip_width_table.sv
// Occupied-width table: one flop per strip, one write port, one combinational
// lookup for the updater and three registered read ports for the selector.
module strip_width_table
    import strip_width_updater_pkg::*;
#(
    parameter int unsigned NUM_STRIPS = DEF_NUM_STRIPS,
    parameter int unsigned WIDTH_W    = DEF_WIDTH_W,
    parameter int unsigned MAX_WIDTH  = DEF_MAX_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               wr_en_i,
    input  logic [ID_W-1:0]    wr_id_i,
    input  logic [WIDTH_W-1:0] wr_width_i,
    input  logic [ID_W-1:0]    lk_id_i,
    output logic [WIDTH_W-1:0] lk_width_o,
    input  logic [ID_W-1:0]    rd_id_0_i,
    input  logic [ID_W-1:0]    rd_id_1_i,
    input  logic [ID_W-1:0]    rd_id_2_i,
    output logic [WIDTH_W-1:0] rd_width_0_o,
    output logic [WIDTH_W-1:0] rd_width_1_o,
    output logic [WIDTH_W-1:0] rd_width_2_o
);

    // Invalid IDs read as a full strip so they never win a least-width pick.
    localparam logic [WIDTH_W-1:0] INVALID_W = WIDTH_W'(MAX_WIDTH);

    logic [WIDTH_W-1:0] widths_q   [NUM_STRIPS];
    logic [WIDTH_W-1:0] widths_d   [NUM_STRIPS];
    logic [ID_W-1:0]    rd_id      [NUM_RD_PORTS];
    logic [WIDTH_W-1:0] rd_width_q [NUM_RD_PORTS];
    logic [WIDTH_W-1:0] rd_width_d [NUM_RD_PORTS];

    assign rd_id[0]     = rd_id_0_i;
    assign rd_id[1]     = rd_id_1_i;
    assign rd_id[2]     = rd_id_2_i;
    assign rd_width_0_o = rd_width_q[0];
    assign rd_width_1_o = rd_width_q[1];
    assign rd_width_2_o = rd_width_q[2];

    // Next table contents: clear wins over the commit write.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            widths_d[i] = widths_q[i];
            if (clear_i) begin
                widths_d[i] = '0;
            end else if (wr_en_i && (wr_id_i == ID_W'(i))) begin
                widths_d[i] = wr_width_i;
            end
        end
    end

    // Registered read ports sample the pre-write table; a clear zeroes valid entries.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            rd_width_d[k] = INVALID_W;
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                if (rd_id[k] == ID_W'(i)) begin
                    rd_width_d[k] = clear_i ? '0 : widths_q[i];
                end
            end
        end
    end

    // Combinational lookup used by the updater while checking a request.
    always_comb begin
        lk_width_o = INVALID_W;
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (lk_id_i == ID_W'(i)) begin
                lk_width_o = widths_q[i];
            end
        end
    end

    // Table and read-port registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                widths_q[i] <= '0;
            end
            for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
                rd_width_q[k] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                widths_q[i] <= widths_d[i];
            end
            for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
                rd_width_q[k] <= rd_width_d[k];
            end
        end
    end

endmodule

// File: rtl/strip_width_updater.sv
// Write end of the strip-width path: accepts placement requests, bounds-checks
// them, commits the new strip width and reports the rectangle x-offset.
module strip_width_updater
    import strip_width_updater_pkg::*;
#(
    parameter int unsigned NUM_STRIPS = DEF_NUM_STRIPS,
    parameter int unsigned MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int unsigned WIDTH_W    = DEF_WIDTH_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               place_valid_i,
    output logic               place_ready_o,
    input  logic [ID_W-1:0]    place_id_i,
    input  logic [WIDTH_W-1:0] place_width_i,
    output logic               place_done_o,
    output logic               place_err_o,
    output logic [WIDTH_W-1:0] place_x_o,
    input  logic [ID_W-1:0]    rd_id_0_i,
    input  logic [ID_W-1:0]    rd_id_1_i,
    input  logic [ID_W-1:0]    rd_id_2_i,
    output logic [WIDTH_W-1:0] rd_width_0_o,
    output logic [WIDTH_W-1:0] rd_width_1_o,
    output logic [WIDTH_W-1:0] rd_width_2_o
);

    localparam logic [WIDTH_W:0] MAX_SUM = (WIDTH_W+1)'(MAX_WIDTH);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] old_q, old_d;
    logic [WIDTH_W-1:0] sum_q, sum_d;
    logic               ok_q, ok_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH_W-1:0] x_q, x_d;

    logic [WIDTH_W-1:0] lk_width;
    logic [WIDTH_W:0]   sum_c;
    logic               ok_c;
    logic               wr_en;

    assign place_done_o = done_q;
    assign place_err_o  = err_q;
    assign place_x_o    = x_q;

    strip_width_table #(
        .NUM_STRIPS (NUM_STRIPS),
        .WIDTH_W    (WIDTH_W),
        .MAX_WIDTH  (MAX_WIDTH)
    ) u_table (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .wr_en_i      (wr_en),
        .wr_id_i      (id_q),
        .wr_width_i   (sum_q),
        .lk_id_i      (id_q),
        .lk_width_o   (lk_width),
        .rd_id_0_i    (rd_id_0_i),
        .rd_id_1_i    (rd_id_1_i),
        .rd_id_2_i    (rd_id_2_i),
        .rd_width_0_o (rd_width_0_o),
        .rd_width_1_o (rd_width_1_o),
        .rd_width_2_o (rd_width_2_o)
    );

    // Widened adder so an oversized rectangle cannot wrap into a legal width.
    always_comb begin
        sum_c = {1'b0, lk_width} + {1'b0, width_q};
        ok_c  = id_in_range(id_q, NUM_STRIPS) && (sum_c <= MAX_SUM);
    end

    // FSM next state, handshake, table write enable and result pulses.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        width_d       = width_q;
        old_d         = old_q;
        sum_d         = sum_q;
        ok_d          = ok_q;
        x_d           = x_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        wr_en         = 1'b0;
        place_ready_o = (state_q == ST_IDLE);
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (place_valid_i) begin
                        id_d    = place_id_i;
                        width_d = place_width_i;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    old_d   = lk_width;
                    // Only the low bits are kept: an accepted sum always fits.
                    sum_d   = sum_c[WIDTH_W-1:0];
                    ok_d    = ok_c;
                    state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (ok_q) begin
                        wr_en  = 1'b1;
                        done_d = 1'b1;
                        x_d    = old_q;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            width_q <= '0;
            old_q   <= '0;
            sum_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            width_q <= width_d;
            old_q   <= old_d;
            sum_q   <= sum_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            err_q   <= err_d;
            x_q     <= x_d;
        end
    end

endmodule

// File: tb/tb_strip_width_updater.sv
// Scoreboard bench for strip_width_updater with a reference table model.
module tb_strip_width_updater;

    localparam int NS   = 12;
    localparam int MAXW = 128;
    localparam int WW   = 8;

    logic          clk, rst_i, clear_i, place_valid_i, place_ready_o;
    logic [3:0]    place_id_i;
    logic [WW-1:0] place_width_i;
    logic          place_done_o, place_err_o;
    logic [WW-1:0] place_x_o;
    logic [3:0]    rd_id_0_i, rd_id_1_i, rd_id_2_i;
    logic [WW-1:0] rd_width_0_o, rd_width_1_o, rd_width_2_o;

    strip_width_updater #(
        .NUM_STRIPS (NS),
        .MAX_WIDTH  (MAXW),
        .WIDTH_W    (WW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .place_valid_i (place_valid_i),
        .place_ready_o (place_ready_o),
        .place_id_i    (place_id_i),
        .place_width_i (place_width_i),
        .place_done_o  (place_done_o),
        .place_err_o   (place_err_o),
        .place_x_o     (place_x_o),
        .rd_id_0_i     (rd_id_0_i),
        .rd_id_1_i     (rd_id_1_i),
        .rd_id_2_i     (rd_id_2_i),
        .rd_width_0_o  (rd_width_0_o),
        .rd_width_1_o  (rd_width_1_o),
        .rd_width_2_o  (rd_width_2_o)
    );

    typedef struct {
        bit err;
        int x;
        int due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   mtbl[16];
    int   mx;
    int   cycle;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_rd(input int id);
        return (id < NS) ? mtbl[id] : MAXW;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mtbl[i] = 0;
    endfunction

    // Reference behaviour of one accepted request; outcome queued for the monitor.
    function automatic void model_place(input int id, input int w);
        int   old;
        bit   ok;
        exp_t e;
        old = exp_rd(id);
        ok  = (id < NS) && (old + w <= MAXW);
        if (ok) begin
            mtbl[id] = old + w;
            mx = old;
        end
        e.err = !ok;
        e.x   = mx;
        e.due = cycle + 2;
        sbq.push_back(e);
    endfunction

    // Monitor: every done/err pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst_i && (place_done_o || place_err_o)) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_pulse: got done=%0d err=%0d expected no pulse (t=%0t)",
                         place_done_o, place_err_o, $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("pulse_err", int'(place_err_o), int'(mon_e.err));
                chk("pulse_done", int'(place_done_o), int'(!mon_e.err));
                chk("pulse_cycle", cycle, mon_e.due);
                chk("place_x", int'(place_x_o), mon_e.x);
            end
        end
    end

    // Present a request, wait for ready, and optionally record it in the model.
    task automatic place(input int id, input int w, input bit push);
        int waited;
        waited = 0;
        place_id_i    = 4'(id);
        place_width_i = WW'(w);
        place_valid_i = 1'b1;
        while (!place_ready_o && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            chk("accept_timeout", waited, 0);
        end
        @(posedge clk); #1;
        if (push) model_place(id, w);
        place_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    task automatic rd_check(input int a, input int b, input int c);
        rd_id_0_i = 4'(a);
        rd_id_1_i = 4'(b);
        rd_id_2_i = 4'(c);
        @(posedge clk); #1;
        chk("rd_width_0", int'(rd_width_0_o), exp_rd(a));
        chk("rd_width_1", int'(rd_width_1_o), exp_rd(b));
        chk("rd_width_2", int'(rd_width_2_o), exp_rd(c));
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int accepts;
        int pre;
        rst_i = 1'b0; clear_i = 1'b0; place_valid_i = 1'b0;
        place_id_i = '0; place_width_i = '0;
        rd_id_0_i = '0; rd_id_1_i = '0; rd_id_2_i = '0;
        model_clear();
        mx = 0;

        // Reset state
        #1 rst_i = 1'b1;
        #2;
        chk("rst_ready", int'(place_ready_o), 1);
        chk("rst_done", int'(place_done_o), 0);
        chk("rst_err", int'(place_err_o), 0);
        chk("rst_x", int'(place_x_o), 0);
        chk("rst_rd0", int'(rd_width_0_o), 0);
        @(posedge clk); @(posedge clk); #1 rst_i = 1'b0;
        @(posedge clk); #1;

        // First placement, then read it back
        place(3, 40, 1);
        drain();
        rd_check(3, 0, 15);

        // Exactly full is legal, one more overflows
        place(3, 88, 1);
        place(3, 1, 1);
        drain();
        rd_check(3, 11, 14);

        // Oversized width on empty strip and out-of-range IDs
        place(5, 200, 1);
        place(15, 7, 1);
        place(12, 0, 1);
        drain();
        rd_check(5, 12, 15);

        // Held valid: one accept per three cycles
        place_id_i = 4'd7; place_width_i = 8'd10; place_valid_i = 1'b1;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            bit acc;
            chk("hold_ready", int'(place_ready_o), (i % 3 == 0) ? 1 : 0);
            acc = place_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                model_place(7, 10);
                accepts++;
            end
        end
        place_valid_i = 1'b0;
        chk("hold_accepts", accepts, 2);
        drain();
        place(7, 0, 1);
        drain();
        rd_check(7, 3, 5);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int id, w;
            id = int'($urandom_range(0, 15));
            w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(129, 255))
                                             : int'($urandom_range(0, 50));
            place(id, w, 1);
        end
        drain();
        for (int j = 0; j < 16; j += 3) rd_check(j, (j + 1) % 16, (j + 2) % 16);

        // Clear during CHECK aborts the request silently
        place(2, 10, 0);
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        model_clear();
        chk("clear_idle", int'(place_ready_o), 1);
        repeat (4) begin @(posedge clk); #1; end
        rd_check(2, 3, 15);

        // A request presented with clear is not accepted
        place_id_i = 4'd1; place_width_i = 8'd5; place_valid_i = 1'b1; clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0; place_valid_i = 1'b0;
        chk("clear_no_accept", int'(place_ready_o), 1);
        repeat (3) begin @(posedge clk); #1; end
        rd_check(1, 2, 0);

        // Read port on the commit edge sees the old value, then the new one
        rd_id_0_i = 4'd2;
        pre = exp_rd(2);
        place(2, 30, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rd_pre_commit", int'(rd_width_0_o), pre);
        @(posedge clk); #1;
        chk("rd_post_commit", int'(rd_width_0_o), exp_rd(2));
        drain();

        // Async reset in COMMIT drops the request
        place(2, 5, 1);
        drain();
        place(4, 50, 0);
        @(posedge clk); #1;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_ready", int'(place_ready_o), 1);
        chk("midrst_done", int'(place_done_o), 0);
        chk("midrst_err", int'(place_err_o), 0);
        chk("midrst_x", int'(place_x_o), 0);
        chk("midrst_rd1", int'(rd_width_1_o), 0);
        model_clear();
        mx = 0;
        @(posedge clk); #1 rst_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rd_check(4, 2, 13);

        // Operation resumes after reset
        place(4, 50, 1);
        drain();
        rd_check(4, 2, 9);

        repeat (3) begin @(posedge clk); #1; end
        chk("final_queue_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
